// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples sclk/cs_n/mosi on clk_in and shifts
// DATA_WIDTH-bit words MSB first, with a one-deep valid/ready transmit holding register.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  sreset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [DATA_WIDTH-1:0]  tx_hold, shift_tx, rx_shift;
    logic                   tx_full, loaded_full;
    logic [CNT_W-1:0]       bit_cnt;

    logic in_shift, sh_rise, sh_fall, word_load, commit, tx_take;

    // The extra delay flop after each chain turns a level change into a one-cycle edge strobe.
    always_ff @(posedge clk_in) begin
        if (sreset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, which is what makes this a shift chain.
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    always_ff @(posedge clk_in) begin
        if (sreset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned, which would infer a latch.
        state_next = state;
        miso_oe    = 1'b0;
        miso       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) state_next = SHIFT;
            end
            SHIFT: begin
                miso_oe = 1'b1;
                miso    = shift_tx[DATA_WIDTH-1];
                busy    = 1'b1;
                if (cs_rise) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // cs_rise outranks any sclk edge seen in the same cycle.
    assign in_shift  = (state == SHIFT);
    assign sh_rise   = in_shift && !cs_rise && sclk_rise;
    assign sh_fall   = in_shift && !cs_rise && sclk_fall;
    assign word_load = (!in_shift && cs_fall) || (sh_fall && bit_cnt == '0);
    assign commit    = sh_rise && bit_cnt == '0;
    assign tx_take   = tx_valid && !tx_full;
    assign tx_ready  = !tx_full;

    always_ff @(posedge clk_in) begin
        if (sreset) begin
            // NOTE: data registers are reset too, because rx_data is architecturally visible and held tx data must be dropped.
            tx_hold     <= '0;
            tx_full     <= 1'b0;
            shift_tx    <= '0;
            loaded_full <= 1'b0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            bit_cnt     <= '0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            if (tx_take) begin
                tx_full <= 1'b1;
                tx_hold <= tx_data;
            end else if (commit && loaded_full) begin
                tx_full <= 1'b0;
            end

            // Loads see the pre-cycle tx_full, so a same-cycle transfer waits for the next word.
            if (word_load) begin
                shift_tx    <= tx_full ? tx_hold : '0;
                loaded_full <= tx_full;
            end else if (sh_fall) begin
                shift_tx <= shift_tx << 1;
            end

            if (commit && !loaded_full) tx_underrun <= 1'b1;

            if ((!in_shift && cs_fall) || (in_shift && cs_rise)) begin
                bit_cnt <= '0;
            end else if (sh_rise) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt  <= '0;
                    rx_data  <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                    rx_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-bangs mode-0 frames at CLK_DIVIDE=10 and
// compares miso, rx words and handshake pulses against hand-computed values.
module tb_spi_slave;

    localparam int HALF = 5;

    logic       clk_in = 1'b0;
    logic       sreset;
    logic       sclk, cs_n, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, tx_underrun, busy;

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_in      (clk_in),
        .sreset      (sreset),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    // Pulse counters, sampled on the falling edge.
    int rx_cnt  = 0;
    int und_cnt = 0;
    always @(negedge clk_in) begin
        if (rx_valid)    rx_cnt  <= rx_cnt + 1;
        if (tx_underrun) und_cnt <= und_cnt + 1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk_in);
        tx_valid = 1'b0;
    endtask

    // Shift nbits of one word MSB first with cs_n already low; optionally offer
    // a new tx word just after the first rising edge.
    task automatic word(input logic [7:0] w, input int nbits, input bit do_push,
                        input logic [7:0] nd, output logic [7:0] got,
                        output logic rdy_mid, output logic busy_mid, output logic oe_mid);
        got = '0;
        rdy_mid = 1'b0; busy_mid = 1'b0; oe_mid = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            mosi = w[7-k];
            repeat (HALF) @(negedge clk_in);
            got[7-k] = miso;
            if (k == 0) begin
                busy_mid = busy;
                oe_mid   = miso_oe;
            end
            sclk = 1'b1;
            repeat (HALF) @(negedge clk_in);
            if (k == 0) begin
                rdy_mid = tx_ready;
                if (do_push) push(nd);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk_in);
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk_in);
    endtask

    typedef struct {
        logic       preload;
        logic [7:0] tx;
        logic [7:0] mosi_w;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_und;
    } vec_t;

    vec_t vecs[5];

    logic [7:0] got;
    logic       rdy, bsy, oe;
    int         r0, u0;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
        vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1};
        vecs[2] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 0};
        vecs[3] = '{1'b1, 8'hFF, 8'h81, 8'hFF, 8'h81, 0};
        vecs[4] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 0};

        sreset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_underrun", tx_underrun, 0);
        check("rst_busy", busy, 0);
        sreset = 1'b0;
        repeat (HALF) @(negedge clk_in);

        // Single-word frames.
        for (int v = 0; v < 5; v++) begin
            r0 = rx_cnt; u0 = und_cnt;
            if (vecs[v].preload) push(vecs[v].tx);
            check($sformatf("v%0d_ready_pre", v), tx_ready, !vecs[v].preload);
            cs_n = 1'b0;
            word(vecs[v].mosi_w, 8, 1'b0, 8'h00, got, rdy, bsy, oe);
            cs_high();
            check($sformatf("v%0d_miso", v), got, vecs[v].exp_miso);
            check($sformatf("v%0d_rx_data", v), rx_data, vecs[v].exp_rx);
            check($sformatf("v%0d_rx_pulses", v), rx_cnt - r0, 1);
            check($sformatf("v%0d_underruns", v), und_cnt - u0, vecs[v].exp_und);
            check($sformatf("v%0d_ready_mid", v), rdy, 1);
            check($sformatf("v%0d_busy_mid", v), bsy, 1);
            check($sformatf("v%0d_oe_mid", v), oe, 1);
            check($sformatf("v%0d_busy_end", v), busy, 0);
        end

        // Two words in one CS: 0x12 then 0x34, mosi 0x55 then 0xAA.
        r0 = rx_cnt; u0 = und_cnt;
        push(8'h12);
        cs_n = 1'b0;
        word(8'h55, 8, 1'b1, 8'h34, got, rdy, bsy, oe);
        check("b2b_miso0", got, 8'h12);
        check("b2b_rx0", rx_data, 8'h55);
        word(8'hAA, 8, 1'b0, 8'h00, got, rdy, bsy, oe);
        cs_high();
        check("b2b_miso1", got, 8'h34);
        check("b2b_rx1", rx_data, 8'hAA);
        check("b2b_rx_pulses", rx_cnt - r0, 2);
        check("b2b_underruns", und_cnt - u0, 0);
        check("b2b_ready_end", tx_ready, 1);

        // Word loaded at the last falling edge survives cs_rise.
        u0 = und_cnt;
        push(8'h81);
        cs_n = 1'b0;
        word(8'h00, 8, 1'b1, 8'h7E, got, rdy, bsy, oe);
        cs_high();
        check("keep_miso0", got, 8'h81);
        check("keep_ready_held", tx_ready, 0);
        cs_n = 1'b0;
        word(8'h11, 8, 1'b0, 8'h00, got, rdy, bsy, oe);
        cs_high();
        check("keep_miso1", got, 8'h7E);
        check("keep_rx", rx_data, 8'h11);
        check("keep_underruns", und_cnt - u0, 0);
        check("keep_ready_end", tx_ready, 1);

        // Abort after 5 rising edges, then a clean frame.
        r0 = rx_cnt; u0 = und_cnt;
        cs_n = 1'b0;
        word(8'hF0, 5, 1'b0, 8'h00, got, rdy, bsy, oe);
        repeat (HALF) @(negedge clk_in);
        cs_n = 1'b1;
        repeat (2) @(negedge clk_in);
        check("abort_busy_early", busy, 1);
        repeat (2) @(negedge clk_in);
        check("abort_busy_late", busy, 0);
        repeat (HALF) @(negedge clk_in);
        check("abort_rx_pulses", rx_cnt - r0, 0);
        check("abort_underruns", und_cnt - u0, 1);
        r0 = rx_cnt;
        push(8'h3C);
        cs_n = 1'b0;
        word(8'hA6, 8, 1'b0, 8'h00, got, rdy, bsy, oe);
        cs_high();
        check("after_abort_miso", got, 8'h3C);
        check("after_abort_rx", rx_data, 8'hA6);
        check("after_abort_pulses", rx_cnt - r0, 1);

        // sreset mid-frame with tx_full set drops the held word.
        push(8'h99);
        cs_n = 1'b0;
        word(8'hFF, 3, 1'b0, 8'h00, got, rdy, bsy, oe);
        push(8'hC7);
        check("sr_ready_before", tx_ready, 0);
        sreset = 1'b1;
        cs_n   = 1'b1;
        @(negedge clk_in);
        check("sr_miso_oe", miso_oe, 0);
        check("sr_tx_ready", tx_ready, 1);
        check("sr_rx_valid", rx_valid, 0);
        check("sr_busy", busy, 0);
        check("sr_rx_data", rx_data, 0);
        sreset = 1'b0;
        repeat (HALF) @(negedge clk_in);
        r0 = rx_cnt; u0 = und_cnt;
        cs_n = 1'b0;
        word(8'h0F, 8, 1'b0, 8'h00, got, rdy, bsy, oe);
        cs_high();
        check("sr_next_miso", got, 8'h00);
        check("sr_next_rx", rx_data, 8'h0F);
        check("sr_next_pulses", rx_cnt - r0, 1);
        check("sr_next_underruns", und_cnt - u0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
